// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, divisor limits and the
// divisor clamp used when a frame starts.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    localparam int                DIV_W           = 16;
    localparam logic [DIV_W-1:0]  DEFAULT_DIVISOR = 16'd5208;
    localparam logic [DIV_W-1:0]  MIN_DIVISOR     = 16'd4;

    // Divisors below MIN_DIVISOR leave no room for a mid-bit sample point.
    function automatic logic [DIV_W-1:0] clamp_divisor(input logic [DIV_W-1:0] div);
        return (div < MIN_DIVISOR) ? MIN_DIVISOR : div;
    endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// Multi-flop synchroniser for the asynchronous rx line (resets to the idle
// high level) plus a falling-edge detector on the synchronised value.
module uart_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchroniser chain and one-cycle history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b1}};
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rx_s    = sync_r[SYNC_STAGES-1];
    assign rx_fall = prev_r & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style deserialiser sampling mid-bit with a divisor
// latched at start detection; reports bytes, framing errors and idle state.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     rx_baud_divisor,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_idle
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_e            state_r, state_s;
    logic [DIV_W-1:0]       cnt_r, cnt_s;
    logic [DIV_W-1:0]       div_q_r, div_q_s;
    logic [DIV_W-1:0]       div_eff_s;
    logic [IDX_W-1:0]       idx_r, idx_s;
    logic [DATA_BITS-1:0]   shift_r, shift_s;
    logic [DATA_BITS-1:0]   data_r, data_s;
    logic                   valid_r, valid_s;
    logic                   ferr_r, ferr_s;
    logic                   idle_r;
    logic                   cnt_zero_s;
    logic                   rx_sync_s;
    logic                   rx_fall_s;

    uart_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .rx_s    (rx_sync_s),
        .rx_fall (rx_fall_s)
    );

    // Next-state and datapath update for the frame FSM.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        div_q_s    = div_q_r;
        idx_s      = idx_r;
        shift_s    = shift_r;
        data_s     = data_r;
        valid_s    = 1'b0;
        ferr_s     = 1'b0;
        div_eff_s  = clamp_divisor(rx_baud_divisor);
        cnt_zero_s = (cnt_r == {DIV_W{1'b0}});
        case (state_r)
            ST_IDLE: begin
                if (rx_fall_s) begin
                    div_q_s = div_eff_s;
                    cnt_s   = (div_eff_s >> 1) - 16'd1;
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (!cnt_zero_s) begin
                    cnt_s = cnt_r - 16'd1;
                end else if (!rx_sync_s) begin
                    cnt_s   = div_q_r - 16'd1;
                    idx_s   = {IDX_W{1'b0}};
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!cnt_zero_s) begin
                    cnt_s = cnt_r - 16'd1;
                end else begin
                    shift_s[idx_r] = rx_sync_s;
                    cnt_s          = div_q_r - 16'd1;
                    if (idx_r == LAST_IDX) begin
                        state_s = ST_STOP;
                    end else begin
                        idx_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_STOP: begin
                if (!cnt_zero_s) begin
                    cnt_s = cnt_r - 16'd1;
                end else begin
                    data_s = shift_r;
                    if (rx_sync_s) begin
                        valid_s = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // A held-low line must return high before a new start is armed.
                if (rx_sync_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BREAK;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; idle tracks the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {DIV_W{1'b0}};
            div_q_r <= MIN_DIVISOR;
            idx_r   <= {IDX_W{1'b0}};
            shift_r <= {DATA_BITS{1'b0}};
            data_r  <= {DATA_BITS{1'b0}};
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            idle_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            div_q_r <= div_q_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            ferr_r  <= ferr_s;
            idle_r  <= (state_s == ST_IDLE);
        end
    end

    assign rx_data   = data_r;
    assign rx_valid  = valid_r;
    assign frame_err = ferr_r;
    assign rx_idle   = idle_r;

endmodule
